// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the execute stage.
// Shift-add multiply, restoring divide, MTHI/MTLO writes and the HI/LO read mux.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_E,
  input  logic             md_start_E,
  input  logic [1:0]       md_op_E,
  input  logic [WIDTH-1:0] src_a_E,
  input  logic [WIDTH-1:0] src_b_E,
  input  logic [1:0]       hilo_dis_E,
  input  logic             hilo_wr_E,
  input  logic             hilo_sel_E,
  output logic             md_run_E,
  output logic [WIDTH-1:0] hilo_E,
  output logic             md_done
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [WIDTH-1:0]   acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q,  acc_lo_d;
  logic [WIDTH-1:0]   opb_q,     opb_d;
  logic               is_div_q,  is_div_d;
  logic               res_neg_q, res_neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               div0_q,    div0_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               run_q,     run_d;
  logic               done_q,    done_d;

  logic               start_ok;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod;

  // Next-state, datapath iteration and result commit
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    opb_d     = opb_q;
    is_div_d  = is_div_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;

    start_ok  = md_start_E & en_E;
    signed_op = ~md_op_E[0];
    a_neg     = signed_op & src_a_E[WIDTH-1];
    b_neg     = signed_op & src_b_E[WIDTH-1];
    a_mag     = a_neg ? WIDTH'(-src_a_E) : src_a_E;
    b_mag     = b_neg ? WIDTH'(-src_b_E) : src_b_E;

    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    rem_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, opb_q};
    rem_sub   = rem_sh[WIDTH-1:0] - opb_q;
    prod      = {acc_hi_q, acc_lo_q};

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          // Multiplier/dividend sits in acc_lo, multiplicand/divisor in opb
          state_d   = S_RUN;
          cnt_d     = '0;
          is_div_d  = md_op_E[1];
          res_neg_d = a_neg ^ b_neg;
          rem_neg_d = a_neg;
          div0_d    = (src_b_E == '0);
          acc_hi_d  = '0;
          acc_lo_d  = md_op_E[1] ? a_mag : b_mag;
          opb_d     = md_op_E[1] ? b_mag : a_mag;
        end else if (hilo_wr_E && en_E) begin
          if (!hilo_dis_E[1]) hi_d = src_a_E;
          if (!hilo_dis_E[0]) lo_d = src_a_E;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          acc_hi_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], rem_ge};
        end else begin
          {acc_hi_d, acc_lo_d} = {mul_sum, acc_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        // A zero divisor leaves the dividend magnitude as remainder, so HI restores it
        if (is_div_q) begin
          hi_d = rem_neg_q ? WIDTH'(-acc_hi_q) : acc_hi_q;
          lo_d = div0_q ? {WIDTH{1'b1}} : (res_neg_q ? WIDTH'(-acc_lo_q) : acc_lo_q);
        end else begin
          {hi_d, lo_d} = res_neg_q ? (2*WIDTH)'(-prod) : prod;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    run_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      is_div_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      run_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      opb_q     <= opb_d;
      is_div_q  <= is_div_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      run_q     <= run_d;
      done_q    <= done_d;
    end
  end

  assign md_run_E = run_q;
  assign md_done  = done_q;
  assign hilo_E   = hilo_sel_E ? hi_q : lo_q;

endmodule
